// File: rtl/reset_seq.sv
// Multi-channel reset sequencer: staged release of NCH active-low resets, then Z80 bus grab with timeout.
// Optional RESET_SEQ_AUTORETRY_EN: up to 3 full re-sequences on BUSAK timeout before reporting an error.
module reset_seq #(
    parameter int NCH           = 3,
    parameter int RST_CNT_SIZE  = 8,
    parameter int STEP_CYCLES   = 16,
    parameter int TO_WIDTH      = 16,
    parameter int BUSAK_TIMEOUT = 50000
) (
    input  logic                         clk_24mhz,
    input  logic                         poweron_rst_n,
    input  logic                         init,
    output logic [NCH-1:0]               rst_n_out,
    output logic                         z80_busrq_n,
    input  logic                         z80_busak_n,
    output logic                         init_in_progress,
    output logic                         timeout_err,
    output logic [$clog2(NCH+1)-1:0]     cur_ch
);

    localparam int CW = $clog2(NCH + 1);
    localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [RST_CNT_SIZE-1:0] HOLD_LAST = {RST_CNT_SIZE{1'b1}};
    localparam logic [SW-1:0]           STEP_LAST = SW'(STEP_CYCLES - 1);
    localparam logic [TO_WIDTH-1:0]     TO_LAST   = TO_WIDTH'(BUSAK_TIMEOUT - 1);
    localparam logic [CW-1:0]           NCH_C     = CW'(NCH);

    localparam logic [2:0] S_HOLD  = 3'd0;
    localparam logic [2:0] S_STEP  = 3'd1;
    localparam logic [2:0] S_BUSRQ = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]              r_state;
    logic [RST_CNT_SIZE-1:0] r_hold_cnt;
    logic [SW-1:0]           r_step_cnt;
    logic [TO_WIDTH-1:0]     r_to_cnt;
    logic [CW-1:0]           r_cur_ch;
    logic [NCH-1:0]          r_rst_n;
    logic                    r_busrq_n;
    logic                    r_iip;
    logic                    r_terr;
    logic                    r_ak_meta;
    logic                    r_ak_s;
`ifdef RESET_SEQ_AUTORETRY_EN
    logic [1:0]              r_retry_cnt;
`endif

    // Idle level of the synchroniser is "not acknowledged" so a restart never sees a stale ack.
    always_ff @(posedge clk_24mhz or negedge poweron_rst_n) begin
        if (!poweron_rst_n) begin
            r_ak_meta <= 1'b1;
            r_ak_s    <= 1'b1;
        end else if (init) begin
            r_ak_meta <= 1'b1;
            r_ak_s    <= 1'b1;
        end else begin
            r_ak_meta <= z80_busak_n;
            r_ak_s    <= r_ak_meta;
        end
    end

    always_ff @(posedge clk_24mhz or negedge poweron_rst_n) begin
        if (!poweron_rst_n) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
            r_step_cnt <= '0;
            r_to_cnt   <= '0;
            r_cur_ch   <= '0;
            r_rst_n    <= '0;
            r_busrq_n  <= 1'b1;
            r_iip      <= 1'b1;
            r_terr     <= 1'b0;
`ifdef RESET_SEQ_AUTORETRY_EN
            r_retry_cnt <= '0;
`endif
        end else if (init) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
            r_step_cnt <= '0;
            r_to_cnt   <= '0;
            r_cur_ch   <= '0;
            r_rst_n    <= '0;
            r_busrq_n  <= 1'b1;
            r_iip      <= 1'b1;
            r_terr     <= 1'b0;
`ifdef RESET_SEQ_AUTORETRY_EN
            r_retry_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_rst_n[0] <= 1'b1;
                        r_cur_ch   <= CW'(1);
                        r_step_cnt <= '0;
                        r_state    <= S_STEP;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + RST_CNT_SIZE'(1);
                    end
                end
                S_STEP: begin
                    if (r_step_cnt == STEP_LAST) begin
                        r_step_cnt <= '0;
                        if (r_cur_ch == NCH_C) begin
                            r_busrq_n <= 1'b0;
                            r_to_cnt  <= '0;
                            r_state   <= S_BUSRQ;
                        end else begin
                            for (int i = 0; i < NCH; i++) begin
                                if (r_cur_ch == CW'(i)) r_rst_n[i] <= 1'b1;
                            end
                            r_cur_ch <= r_cur_ch + CW'(1);
                        end
                    end else begin
                        r_step_cnt <= r_step_cnt + SW'(1);
                    end
                end
                S_BUSRQ: begin
                    // Ack is tested first so an ack landing on the timeout edge still wins.
                    if (!r_ak_s) begin
                        r_iip   <= 1'b0;
                        r_state <= S_DONE;
                    end else if (r_to_cnt == TO_LAST) begin
`ifdef RESET_SEQ_AUTORETRY_EN
                        if (r_retry_cnt != 2'd3) begin
                            r_retry_cnt <= r_retry_cnt + 2'd1;
                            r_rst_n     <= '0;
                            r_busrq_n   <= 1'b1;
                            r_hold_cnt  <= '0;
                            r_step_cnt  <= '0;
                            r_to_cnt    <= '0;
                            r_cur_ch    <= '0;
                            r_state     <= S_HOLD;
                        end else begin
                            r_terr    <= 1'b1;
                            r_busrq_n <= 1'b1;
                            r_state   <= S_ERR;
                        end
`else
                        r_terr    <= 1'b1;
                        r_busrq_n <= 1'b1;
                        r_state   <= S_ERR;
`endif
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_WIDTH'(1);
                    end
                end
                S_DONE, S_ERR: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= S_HOLD;
                end
            endcase
        end
    end

    assign rst_n_out        = r_rst_n;
    assign z80_busrq_n      = r_busrq_n;
    assign init_in_progress = r_iip;
    assign timeout_err      = r_terr;
    assign cur_ch           = r_cur_ch;

endmodule

// File: tb/tb_reset_seq.sv
// Self-checking bench for reset_seq: timing table, hand-written corner sequences and random stimulus vs a model.
// Expectations follow RESET_SEQ_AUTORETRY_EN when it is defined for the build.
module tb_reset_seq;

    localparam int NCH  = 3;
    localparam int RCS  = 4;
    localparam int STEP = 4;
    localparam int TOW  = 16;
    localparam int TMO  = 100;
    localparam int CW   = $clog2(NCH + 1);
    localparam int W    = NCH + 3 + CW;
    localparam int HOLD = 1 << RCS;
    localparam int T_RQ = HOLD + NCH * STEP;
`ifdef RESET_SEQ_AUTORETRY_EN
    localparam int MAX_RETRY = 3;
`else
    localparam int MAX_RETRY = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           init = 1'b0;
    logic           busak_n = 1'b1;
    logic [NCH-1:0] rst_out;
    logic           busrq_n;
    logic           iip;
    logic           terr;
    logic [CW-1:0]  cur;

    always #5 clk = ~clk;

    reset_seq #(
        .NCH(NCH), .RST_CNT_SIZE(RCS), .STEP_CYCLES(STEP),
        .TO_WIDTH(TOW), .BUSAK_TIMEOUT(TMO)
    ) dut (
        .clk_24mhz(clk),
        .poweron_rst_n(rst_n),
        .init(init),
        .rst_n_out(rst_out),
        .z80_busrq_n(busrq_n),
        .z80_busak_n(busak_n),
        .init_in_progress(iip),
        .timeout_err(terr),
        .cur_ch(cur)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position in the sequence as an edge count, plus done/err flags.
    int m_t;
    bit m_done;
    bit m_err;
    int m_retries;
    bit m_h1;
    bit m_h2;
    int since;

    task automatic model_restart();
        m_t = 0; m_done = 0; m_err = 0; m_retries = 0;
        m_h1 = 1; m_h2 = 1; since = 0;
    endtask

    task automatic model_edge();
        int tn;
        if (!rst_n || init) begin
            model_restart();
        end else begin
            since++;
            if (!m_done && !m_err) begin
                tn = m_t + 1;
                if (tn > T_RQ && !m_h2) begin
                    m_done = 1;
                    m_t = tn;
                end else if (tn == T_RQ + TMO) begin
                    if (m_retries < MAX_RETRY) begin
                        m_retries++;
                        m_t = 0;
                    end else begin
                        m_err = 1;
                        m_t = tn;
                    end
                end else begin
                    m_t = tn;
                end
            end
            m_h2 = m_h1;
            m_h1 = busak_n;
        end
    endtask

    function automatic logic [W-1:0] pk(logic [NCH-1:0] r, logic b, logic i, logic e, int c);
        return {r, b, i, e, CW'(c)};
    endfunction

    function automatic logic [W-1:0] model_exp();
        logic [NCH-1:0] r;
        int c;
        c = 0;
        for (int i = 0; i < NCH; i++) begin
            r[i] = (m_t >= HOLD + i * STEP);
            if (r[i]) c++;
        end
        return pk(r, (m_t < T_RQ) || m_err, !m_done, m_err, c);
    endfunction

    task automatic cmp(string name, logic [W-1:0] exp);
        logic [W-1:0] got;
        got = {rst_out, busrq_n, iip, terr, cur};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: rst/busrq/iip/err/cur got %b required %b", name, since, got, exp);
        end
    endtask

    task automatic cmp_int(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run_to(int n);
        while (since < n) begin
            tick();
            cmp("model", model_exp());
        end
    endtask

    task automatic pulse_init();
        init = 1'b1;
        tick();
        cmp("init_pulse", pk('0, 1, 1, 0, 0));
        init = 1'b0;
    endtask

    typedef struct {
        int             t;
        logic [NCH-1:0] rst;
        logic           busrq_n;
        logic           iip;
        logic           err;
        int             cur;
    } vec_t;

    vec_t vecs[$];
    localparam logic [W-1:0] RESET_VALS = {{NCH{1'b0}}, 1'b1, 1'b1, 1'b0, {CW{1'b0}}};
    localparam logic [W-1:0] DONE_VALS  = {{NCH{1'b1}}, 1'b0, 1'b0, 1'b0, CW'(NCH)};

    initial begin
        int resq;
        logic prev0;

        vecs.push_back('{1,   3'b000, 1'b1, 1'b1, 1'b0, 0});
        vecs.push_back('{15,  3'b000, 1'b1, 1'b1, 1'b0, 0});
        vecs.push_back('{16,  3'b001, 1'b1, 1'b1, 1'b0, 1});
        vecs.push_back('{19,  3'b001, 1'b1, 1'b1, 1'b0, 1});
        vecs.push_back('{20,  3'b011, 1'b1, 1'b1, 1'b0, 2});
        vecs.push_back('{23,  3'b011, 1'b1, 1'b1, 1'b0, 2});
        vecs.push_back('{24,  3'b111, 1'b1, 1'b1, 1'b0, 3});
        vecs.push_back('{27,  3'b111, 1'b1, 1'b1, 1'b0, 3});
        vecs.push_back('{28,  3'b111, 1'b0, 1'b1, 1'b0, 3});
        vecs.push_back('{127, 3'b111, 1'b0, 1'b1, 1'b0, 3});
`ifdef RESET_SEQ_AUTORETRY_EN
        vecs.push_back('{128, 3'b000, 1'b1, 1'b1, 1'b0, 0});
        vecs.push_back('{143, 3'b000, 1'b1, 1'b1, 1'b0, 0});
        vecs.push_back('{144, 3'b001, 1'b1, 1'b1, 1'b0, 1});
`else
        vecs.push_back('{128, 3'b111, 1'b1, 1'b1, 1'b1, 3});
        vecs.push_back('{143, 3'b111, 1'b1, 1'b1, 1'b1, 3});
        vecs.push_back('{144, 3'b111, 1'b1, 1'b1, 1'b1, 3});
`endif

        // Power-on reset: outputs take reset values asynchronously and hold across an edge.
        #1 rst_n = 1'b0;
        model_restart();
        #1 cmp("reset_state", RESET_VALS);
        @(posedge clk); #1;
        cmp("reset_held", RESET_VALS);
        #2 rst_n = 1'b1;
        $display("reset checked, released at %0t", $time);

        foreach (vecs[k]) begin
            run_to(vecs[k].t);
            cmp($sformatf("table_edge%0d", vecs[k].t),
                pk(vecs[k].rst, vecs[k].busrq_n, vecs[k].iip, vecs[k].err, vecs[k].cur));
            $display("vector edge %0d: rst=%b busrq_n=%b iip=%b err=%b cur=%0d", vecs[k].t, rst_out, busrq_n, iip, terr, cur);
        end

        // Ack 5 cycles after busrq, then ignored once done.
        pulse_init();
        run_to(T_RQ + 5);
        busak_n = 1'b0;
        tick(); tick();
        cmp("ack_wait", pk('1, 0, 1, 0, NCH));
        tick();
        cmp("ack_done", DONE_VALS);
        busak_n = 1'b1;
        repeat (10) tick();
        cmp("ack_ignored", DONE_VALS);
        $display("ack sequence done at edge %0d", since);

        // Init pulse in DONE and mid-STEP: identical retiming afterwards.
        pulse_init();
        run_to(HOLD);
        cmp("rerun_rel0", pk(3'b001, 1, 1, 0, 1));
        run_to(22);
        pulse_init();
        run_to(HOLD - 1);
        cmp("midstep_hold", RESET_VALS);
        run_to(HOLD);
        cmp("midstep_rel0", pk(3'b001, 1, 1, 0, 1));
        run_to(T_RQ);
        cmp("midstep_busrq", pk('1, 0, 1, 0, NCH));
        $display("init restart sequences done");

        // Init held 10 cycles.
        init = 1'b1;
        repeat (10) tick();
        cmp("init_held", RESET_VALS);
        init = 1'b0;
        run_to(HOLD - 1);
        cmp("init_held_15", RESET_VALS);
        run_to(HOLD);
        cmp("init_held_16", pk(3'b001, 1, 1, 0, 1));
        $display("held-init sequence done");

        // Async reset mid-BUSRQ.
        run_to(60);
        rst_n = 1'b0;
        model_restart();
        #1 cmp("async_reset", RESET_VALS);
        #2 rst_n = 1'b1;
        run_to(T_RQ);
        cmp("after_async", pk('1, 0, 1, 0, NCH));
        $display("async reset sequence done");

        // Ack sampled on the very edge the timeout would fire: ack wins.
        run_to(T_RQ + TMO - 3);
        busak_n = 1'b0;
        tick(); tick();
        cmp("tie_before", pk('1, 0, 1, 0, NCH));
        tick();
        cmp("tie_ack_wins", DONE_VALS);
        busak_n = 1'b1;
        $display("ack/timeout tie done at edge %0d", since);

        // Timeout with no ack: count re-sequences before the error.
        pulse_init();
        resq = 0;
        prev0 = rst_out[0];
        for (int n = 0; n < 800 && !terr; n++) begin
            tick();
            cmp("timeout_model", model_exp());
            if (prev0 && !rst_out[0]) resq++;
            prev0 = rst_out[0];
        end
        cmp_int("timeout_edge", since, (MAX_RETRY + 1) * (T_RQ + TMO));
        cmp_int("resequences", resq, MAX_RETRY);
        cmp("err_state", pk('1, 1, 1, 1, NCH));
        $display("timeout after %0d resequences at edge %0d", resq, since);

        // Random init/busak/async-reset traffic against the model.
        pulse_init();
        for (int n = 0; n < 6000; n++) begin
            int r;
            r = $urandom_range(0, 999);
            init = (r < 4);
            if ($urandom_range(0, 39) == 0) busak_n = ~busak_n;
            if (r == 999) begin
                rst_n = 1'b0;
                model_restart();
                #1 cmp("rand_async", model_exp());
                #2 rst_n = 1'b1;
            end
            tick();
            cmp("random", model_exp());
        end
        init = 1'b0;
        $display("random phase done, %0d checks so far", n_checks);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
